// File: rtl/ball_engine.sv
// ball_engine: registered pong ball engine.
//
// Owns the ball position and direction, the IDLE/PLAY/OVER game state and
// the per-side miss scores. The ball advances one cell per tick while in
// PLAY, reflecting off the side walls and off the top and bottom paddles.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   tick         step enable, one ball move per tick
//   serve        start play from IDLE / return to IDLE from OVER
//   paddle_top   leftmost column of the top paddle
//   paddle_down  leftmost column of the bottom paddle
//   ball_x/y     ball column / row
//   dir_x        1 = increasing x, 0 = decreasing
//   dir_y        1 = downward, 0 = upward
//   playing      high while in PLAY
//   hit          one-cycle pulse on a paddle reflection
//   endgame      high while in OVER
//   loser        0 = top missed, 1 = bottom missed (valid with endgame)
//   score_top    misses by the bottom player (saturating)
//   score_down   misses by the top player (saturating)
module ball_engine #(
    parameter int COORD_W = 3,
    parameter int FIELD_W = 8,
    parameter int FIELD_H = 8,
    parameter int PAD_W   = 3,
    parameter int START_X = 3,
    parameter int START_Y = 3,
    parameter int SCORE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               serve,
    input  logic [COORD_W-1:0] paddle_top,
    input  logic [COORD_W-1:0] paddle_down,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic               dir_x,
    output logic               dir_y,
    output logic               playing,
    output logic               hit,
    output logic               endgame,
    output logic               loser,
    output logic [SCORE_W-1:0] score_top,
    output logic [SCORE_W-1:0] score_down
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [COORD_W-1:0] X_MIN      = COORD_W'(1);
    localparam logic [COORD_W-1:0] X_MAX      = COORD_W'(FIELD_W - 2);
    localparam logic [COORD_W-1:0] Y_MIN      = COORD_W'(1);
    localparam logic [COORD_W-1:0] Y_MAX      = COORD_W'(FIELD_H - 2);
    localparam logic [COORD_W-1:0] Y_TOP_GOAL = COORD_W'(0);
    localparam logic [COORD_W-1:0] Y_BOT_GOAL = COORD_W'(FIELD_H - 1);
    localparam logic [COORD_W-1:0] Y_TOP_BNC  = COORD_W'(2);
    localparam logic [COORD_W-1:0] Y_BOT_BNC  = COORD_W'(FIELD_H - 3);
    localparam logic [COORD_W-1:0] SX         = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] SY         = COORD_W'(START_Y);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
    localparam logic [COORD_W:0]   PAD_SPAN   = (COORD_W + 1)'(PAD_W - 1);

    // Paddle cover test done one bit wider so a paddle hanging off the
    // right edge of the field does not wrap back onto column 0.
    function automatic logic covers(input logic [COORD_W-1:0] p,
                                    input logic [COORD_W-1:0] x);
        logic [COORD_W:0] pe;
        logic [COORD_W:0] xe;
        pe = {1'b0, p};
        xe = {1'b0, x};
        return (pe <= xe) && (xe <= pe + PAD_SPAN);
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + 1'b1;
    endfunction

    state_t             state_q, state_d;
    logic [COORD_W-1:0] bx_q, bx_d;
    logic [COORD_W-1:0] by_q, by_d;
    logic               dx_q, dx_d;
    logic               dy_q, dy_d;
    logic               hit_q, hit_d;
    logic               endgame_q, endgame_d;
    logic               loser_q, loser_d;
    logic [SCORE_W-1:0] st_q, st_d;
    logic [SCORE_W-1:0] sd_q, sd_d;

    // X step: wall reflection and move on the same tick.
    logic               ndx;
    logic [COORD_W-1:0] nbx;
    logic               cov_top;
    logic               cov_down;

    assign ndx      = (bx_q == X_MIN) ? 1'b1 : (bx_q == X_MAX) ? 1'b0 : dx_q;
    assign nbx      = ndx ? bx_q + 1'b1 : bx_q - 1'b1;
    assign cov_top  = covers(paddle_top, bx_q);
    assign cov_down = covers(paddle_down, bx_q);

    always_comb begin
        state_d   = state_q;
        bx_d      = bx_q;
        by_d      = by_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        hit_d     = 1'b0;
        endgame_d = endgame_q;
        loser_d   = loser_q;
        st_d      = st_q;
        sd_d      = sd_q;

        case (state_q)
            IDLE: begin
                // Ball is already parked at the serve position here.
                if (serve) begin
                    state_d = PLAY;
                end
            end

            PLAY: begin
                if (tick) begin
                    bx_d = nbx;
                    dx_d = ndx;
                    if ((by_q == Y_MIN) && !dy_q) begin
                        if (cov_top) begin
                            dy_d  = 1'b1;
                            by_d  = Y_TOP_BNC;
                            hit_d = 1'b1;
                        end else begin
                            by_d      = Y_TOP_GOAL;
                            state_d   = OVER;
                            endgame_d = 1'b1;
                            loser_d   = 1'b0;
                            sd_d      = sat_inc(sd_q);
                        end
                    end else if ((by_q == Y_MAX) && dy_q) begin
                        if (cov_down) begin
                            dy_d  = 1'b0;
                            by_d  = Y_BOT_BNC;
                            hit_d = 1'b1;
                        end else begin
                            by_d      = Y_BOT_GOAL;
                            state_d   = OVER;
                            endgame_d = 1'b1;
                            loser_d   = 1'b1;
                            st_d      = sat_inc(st_q);
                        end
                    end else begin
                        by_d = dy_q ? by_q + 1'b1 : by_q - 1'b1;
                    end
                end
            end

            OVER: begin
                // Everything holds until serve; scores survive the restart.
                if (serve) begin
                    state_d   = IDLE;
                    bx_d      = SX;
                    by_d      = SY;
                    dx_d      = 1'b1;
                    dy_d      = 1'b1;
                    endgame_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bx_q      <= SX;
            by_q      <= SY;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            hit_q     <= 1'b0;
            endgame_q <= 1'b0;
            loser_q   <= 1'b0;
            st_q      <= '0;
            sd_q      <= '0;
        end else begin
            state_q   <= state_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            hit_q     <= hit_d;
            endgame_q <= endgame_d;
            loser_q   <= loser_d;
            st_q      <= st_d;
            sd_q      <= sd_d;
        end
    end

    assign ball_x     = bx_q;
    assign ball_y     = by_q;
    assign dir_x      = dx_q;
    assign dir_y      = dy_q;
    assign playing    = (state_q == PLAY);
    assign hit        = hit_q;
    assign endgame    = endgame_q;
    assign loser      = loser_q;
    assign score_top  = st_q;
    assign score_down = sd_q;

endmodule

// File: tb/tb_ball_engine.sv
module tb_ball_engine;

    localparam int COORD_W = 3;
    localparam int FIELD_W = 8;
    localparam int FIELD_H = 8;
    localparam int PAD_W   = 3;
    localparam int START_X = 3;
    localparam int START_Y = 3;
    localparam int SCORE_W = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               tick;
    logic               serve;
    logic [COORD_W-1:0] paddle_top;
    logic [COORD_W-1:0] paddle_down;
    logic [COORD_W-1:0] ball_x, ball_y;
    logic               dir_x, dir_y, playing, hit, endgame, loser;
    logic [SCORE_W-1:0] score_top, score_down;

    // Second instance with a 2-bit score, sharing all inputs.
    logic [COORD_W-1:0] ball_x_s, ball_y_s;
    logic               dir_x_s, dir_y_s, playing_s, hit_s, endgame_s, loser_s;
    logic [1:0]         score_top_s, score_down_s;

    int checks = 0;
    int errors = 0;

    ball_engine #(
        .COORD_W(COORD_W), .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .PAD_W(PAD_W),
        .START_X(START_X), .START_Y(START_Y), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .serve(serve),
        .paddle_top(paddle_top), .paddle_down(paddle_down),
        .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
        .playing(playing), .hit(hit), .endgame(endgame), .loser(loser),
        .score_top(score_top), .score_down(score_down)
    );

    ball_engine #(
        .COORD_W(COORD_W), .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .PAD_W(PAD_W),
        .START_X(START_X), .START_Y(START_Y), .SCORE_W(2)
    ) dut_s (
        .clk(clk), .reset(reset), .tick(tick), .serve(serve),
        .paddle_top(paddle_top), .paddle_down(paddle_down),
        .ball_x(ball_x_s), .ball_y(ball_y_s), .dir_x(dir_x_s), .dir_y(dir_y_s),
        .playing(playing_s), .hit(hit_s), .endgame(endgame_s), .loser(loser_s),
        .score_top(score_top_s), .score_down(score_down_s)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural reference model ----------------
    // Game phase kept as a string; positions as plain integers.
    string m_phase;
    int    m_x, m_y, m_vx, m_vy;     // velocities are +1 / -1
    int    m_hit, m_end, m_loser, m_st, m_sd;
    int    m_smax;

    function automatic bit paddle_covers(int p, int x);
        return (p <= x) && (x <= p + PAD_W - 1);
    endfunction

    task automatic model_reset();
        m_phase = "idle";
        m_x = START_X; m_y = START_Y; m_vx = 1; m_vy = 1;
        m_hit = 0; m_end = 0; m_loser = 0; m_st = 0; m_sd = 0;
        m_smax = (1 << SCORE_W) - 1;
    endtask

    task automatic model_step(input bit t, input bit s, input int pt, input int pd);
        int nx_v;
        m_hit = 0;
        if (m_phase == "idle") begin
            if (s) m_phase = "play";
        end else if (m_phase == "play") begin
            if (t) begin
                nx_v = (m_x == 1) ? 1 : (m_x == FIELD_W - 2) ? -1 : m_vx;
                if (m_y == 1 && m_vy < 0) begin
                    if (paddle_covers(pt, m_x)) begin
                        m_vy = 1; m_y = 2; m_hit = 1;
                    end else begin
                        m_y = 0; m_phase = "over"; m_end = 1; m_loser = 0;
                        m_sd = (m_sd < m_smax) ? m_sd + 1 : m_sd;
                    end
                end else if (m_y == FIELD_H - 2 && m_vy > 0) begin
                    if (paddle_covers(pd, m_x)) begin
                        m_vy = -1; m_y = FIELD_H - 3; m_hit = 1;
                    end else begin
                        m_y = FIELD_H - 1; m_phase = "over"; m_end = 1; m_loser = 1;
                        m_st = (m_st < m_smax) ? m_st + 1 : m_st;
                    end
                end else begin
                    m_y = m_y + m_vy;
                end
                m_x  = m_x + nx_v;
                m_vx = nx_v;
            end
        end else begin
            if (s) begin
                m_phase = "idle";
                m_x = START_X; m_y = START_Y; m_vx = 1; m_vy = 1; m_end = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, and return 1ns after the edge.
    task automatic step(input bit t, input bit s, input int pt, input int pd);
        tick        = t;
        serve       = s;
        paddle_top  = COORD_W'(pt);
        paddle_down = COORD_W'(pd);
        model_step(t, s, pt, pd);
        @(posedge clk);
        #1;
        tick  = 1'b0;
        serve = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; tick = 1'b0; serve = 1'b0; paddle_top = '0; paddle_down = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ball_x, ball_y, dir_x, dir_y, playing, hit, endgame, loser} !== {3'd3, 3'd3, 1'b1, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: got x=%0d y=%0d dx=%0d dy=%0d pl=%0d hit=%0d end=%0d los=%0d, want 3 3 1 1 0 0 0 0",
                     ball_x, ball_y, dir_x, dir_y, playing, hit, endgame, loser);
        end
        checks++;
        if (score_top !== 4'd0 || score_down !== 4'd0) begin
            errors++;
            $display("FAIL reset_scores: got %0d/%0d want 0/0", score_top, score_down);
        end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        checks++;
        if (ball_x !== 3'd3 || ball_y !== 3'd3 || playing !== 1'b0) begin
            errors++;
            $display("FAIL idle_tick: got (%0d,%0d) pl=%0d want (3,3) pl=0", ball_x, ball_y, playing);
        end
    endtask

    task automatic test_serve_and_hit();
        step(1, 1, 0, 0);   // serve with a simultaneous tick: no move
        checks++;
        if (playing !== 1'b1 || ball_x !== 3'd3 || ball_y !== 3'd3) begin
            errors++;
            $display("FAIL serve: got pl=%0d (%0d,%0d) want pl=1 (3,3)", playing, ball_x, ball_y);
        end
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, 0, 0);
            checks++;
            if (ball_x !== COORD_W'(3 + i) || ball_y !== COORD_W'(3 + i) || hit !== 1'b0) begin
                errors++;
                $display("FAIL move_%0d: got (%0d,%0d) hit=%0d want (%0d,%0d) hit=0", i, ball_x, ball_y, hit, 3 + i, 3 + i);
            end
        end
        step(1, 0, 0, 4);
        checks++;
        if ({ball_x, ball_y, dir_x, dir_y, hit} !== {3'd5, 3'd5, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL bottom_hit: got (%0d,%0d) d=(%0d,%0d) hit=%0d want (5,5) d=(0,0) hit=1",
                     ball_x, ball_y, dir_x, dir_y, hit);
        end
        step(0, 0, 0, 4);
        checks++;
        if (hit !== 1'b0 || ball_x !== 3'd5 || ball_y !== 3'd5) begin
            errors++;
            $display("FAIL hit_pulse: got hit=%0d (%0d,%0d) want hit=0 (5,5)", hit, ball_x, ball_y);
        end
    endtask

    task automatic test_top_miss();
        for (int i = 1; i <= 4; i++) step(1, 0, 5, 0);
        checks++;
        if (ball_x !== 3'd1 || ball_y !== 3'd1) begin
            errors++;
            $display("FAIL approach_top: got (%0d,%0d) want (1,1)", ball_x, ball_y);
        end
        // x reflects off the left wall on the same tick as the top miss
        step(1, 0, 5, 0);
        checks++;
        if ({ball_x, ball_y, dir_x, endgame, loser, playing, score_down, score_top} !==
            {3'd2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0}) begin
            errors++;
            $display("FAIL top_miss: got (%0d,%0d) dx=%0d end=%0d los=%0d pl=%0d sd=%0d st=%0d want (2,0) 1 1 0 0 1 0",
                     ball_x, ball_y, dir_x, endgame, loser, playing, score_down, score_top);
        end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++;
        if ({ball_x, ball_y, endgame, score_down} !== {3'd2, 3'd0, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL over_hold: got (%0d,%0d) end=%0d sd=%0d want (2,0) 1 1", ball_x, ball_y, endgame, score_down);
        end
        step(0, 1, 0, 0);
        checks++;
        if ({ball_x, ball_y, dir_x, dir_y, endgame, playing, score_down} !== {3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1}) begin
            errors++;
            $display("FAIL restart_idle: got (%0d,%0d) d=(%0d,%0d) end=%0d pl=%0d sd=%0d want (3,3) (1,1) 0 0 1",
                     ball_x, ball_y, dir_x, dir_y, endgame, playing, score_down);
        end
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        checks++;
        if (ball_x !== 3'd4 || ball_y !== 3'd4 || playing !== 1'b1) begin
            errors++;
            $display("FAIL resume: got (%0d,%0d) pl=%0d want (4,4) pl=1", ball_x, ball_y, playing);
        end
    endtask

    task automatic test_bottom_miss();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++;
        if ({ball_x, ball_y, dir_x, dir_y, endgame, loser, playing, score_top, score_down} !==
            {3'd5, 3'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1}) begin
            errors++;
            $display("FAIL bottom_miss: got (%0d,%0d) d=(%0d,%0d) end=%0d los=%0d pl=%0d st=%0d sd=%0d want (5,7) (0,1) 1 1 0 1 1",
                     ball_x, ball_y, dir_x, dir_y, endgame, loser, playing, score_top, score_down);
        end
        step(1, 0, 0, 0);
        step(1, 0, 7, 7);
        checks++;
        if ({ball_x, ball_y, hit, endgame, loser, score_top} !== {3'd5, 3'd7, 1'b0, 1'b1, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL bottom_over_hold: got (%0d,%0d) hit=%0d end=%0d los=%0d st=%0d want (5,7) 0 1 1 1",
                     ball_x, ball_y, hit, endgame, loser, score_top);
        end
    endtask

    task automatic test_edge_paddle();
        step(0, 1, 0, 0);   // OVER -> IDLE
        step(0, 1, 0, 0);   // IDLE -> PLAY
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(1, 0, 0, 6);
        checks++;
        if (hit !== 1'b1 || ball_x !== 3'd5 || ball_y !== 3'd5) begin
            errors++;
            $display("FAIL edge_hit: got hit=%0d (%0d,%0d) want hit=1 (5,5)", hit, ball_x, ball_y);
        end
        #2; reset = 1'b1; #1; reset = 1'b0;
        model_reset();
        step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(1, 0, 0, 7);
        checks++;
        if ({hit, endgame, loser, ball_x, ball_y, score_top} !== {1'b0, 1'b1, 1'b1, 3'd5, 3'd7, 4'd1}) begin
            errors++;
            $display("FAIL edge_nowrap: got hit=%0d end=%0d los=%0d (%0d,%0d) st=%0d want 0 1 1 (5,7) 1",
                     hit, endgame, loser, ball_x, ball_y, score_top);
        end
    endtask

    task automatic test_saturation();
        for (int k = 2; k <= 6; k++) begin
            step(0, 1, 0, 0);
            step(0, 1, 0, 0);
            for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
            checks++;
            if (score_top !== SCORE_W'(k) || score_top_s !== 2'((k > 3) ? 3 : k)) begin
                errors++;
                $display("FAIL saturate_%0d: got st=%0d st2=%0d want %0d %0d",
                         k, score_top, score_top_s, k, (k > 3) ? 3 : k);
            end
        end
    endtask

    task automatic test_async_reset();
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++;
        if (ball_x !== 3'd5 || ball_y !== 3'd5 || playing !== 1'b1) begin
            errors++;
            $display("FAIL pre_async: got (%0d,%0d) pl=%0d want (5,5) 1", ball_x, ball_y, playing);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({ball_x, ball_y, dir_x, dir_y, playing, endgame, score_top, score_down} !==
            {3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0}) begin
            errors++;
            $display("FAIL async_reset: got (%0d,%0d) d=(%0d,%0d) pl=%0d end=%0d st=%0d sd=%0d want (3,3) (1,1) 0 0 0 0",
                     ball_x, ball_y, dir_x, dir_y, playing, endgame, score_top, score_down);
        end
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [31:0] got, want;
        int t, s, pt, pd;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            t  = int'($urandom_range(0, 3) != 0);
            s  = int'($urandom_range(0, 15) == 0);
            pt = int'($urandom_range(0, 7));
            pd = int'($urandom_range(0, 7));
            step(t[0], s[0], pt, pd);
            got  = {8'd0, 2'd0, ball_x, ball_y, dir_x, dir_y, playing, hit, endgame, loser, score_top, score_down};
            want = {8'd0, 2'd0, 3'(m_x), 3'(m_y), (m_vx > 0), (m_vy > 0), (m_phase == "play"),
                    m_hit[0], m_end[0], m_loser[0], 4'(m_st), 4'(m_sd)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL random_%0d: got %h want %h (t=%0d s=%0d pt=%0d pd=%0d)", n, got, want, t, s, pt, pd);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        tick = 1'b0; serve = 1'b0; paddle_top = '0; paddle_down = '0;
        model_reset();
        test_reset();
        test_serve_and_hit();
        test_top_miss();
        test_bottom_miss();
        test_edge_paddle();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
